// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and constants for the data-memory arbiter.
//   state_t              - sequencer state encoding (IDLE/BUSY/DONE)
//   DMEM_TIMEOUT_DEFAULT - default ack wait budget in cycles
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DMEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports, the memory port and busy.
//   slave  - arbiter side (requests/mem ack in, responses/mem strobe out)
//   master - environment side (requesters plus memory model)
interface dmem_arbiter_if;
  logic        i_m0_stb, i_m1_stb;
  logic        i_m0_we, i_m1_we;
  logic [31:0] i_m0_addr, i_m1_addr;
  logic [31:0] i_m0_wdata, i_m1_wdata;
  logic [3:0]  i_m0_be, i_m1_be;
  logic        o_m0_ack, o_m1_ack;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic        o_m0_err, o_m1_err;
  logic        o_stb;
  logic        o_MemSrc;
  logic [31:0] o_addr;
  logic [31:0] o_wr_data;
  logic [3:0]  o_be;
  logic        i_rd_ack;
  logic [31:0] i_read_data;
  logic        o_busy;

  modport slave (
    input  i_m0_stb, i_m1_stb, i_m0_we, i_m1_we, i_m0_addr, i_m1_addr,
           i_m0_wdata, i_m1_wdata, i_m0_be, i_m1_be, i_rd_ack, i_read_data,
    output o_m0_ack, o_m1_ack, o_m0_rdata, o_m1_rdata, o_m0_err, o_m1_err,
           o_stb, o_MemSrc, o_addr, o_wr_data, o_be, o_busy
  );

  modport master (
    output i_m0_stb, i_m1_stb, i_m0_we, i_m1_we, i_m0_addr, i_m1_addr,
           i_m0_wdata, i_m1_wdata, i_m0_be, i_m1_be, i_rd_ack, i_read_data,
    input  o_m0_ack, o_m1_ack, o_m0_rdata, o_m1_rdata, o_m0_err, o_m1_err,
           o_stb, o_MemSrc, o_addr, o_wr_data, o_be, o_busy
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant.
//   req[1:0] - request vector          vld - at least one request
//   upd      - commit gnt as last      gnt - granted index (0/1)
// Ties go to the index not recorded in last; last resets to 1 so index 0
// wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       vld,
  output logic       gnt
);
  logic last;

  assign vld = |req;
  // single request: that one; both: the one not served last time
  assign gnt = (&req) ? ~last : ~req[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last <= 1'b1;
    else if (upd) last <= gnt;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: grants the single data-memory port to one of two masters,
// drives the memory strobe/address/data, waits for the memory ack (or a
// timeout) and returns a one-cycle registered ack/rdata/err to the winner.
//   clk, rst_n - clock, async active-low reset
//   bus        - requester, memory and busy signals (dmem_arbiter_if.slave)
//   TIMEOUT    - cycles o_stb stays high without ack before abort (1..255)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);
  state_t           state;
  logic [7:0]       cnt;
  logic             cur;        // master owning the current transaction
  logic             arb_vld, arb_gnt, upd;
  logic             busy, stb, we;
  logic [31:0]      addr, wdata;
  logic [3:0]       be;
  logic [1:0]       ack, err;
  logic [1:0][31:0] rdata;

  assign upd = (state == ST_IDLE) && arb_vld;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.i_m1_stb, bus.i_m0_stb}),
    .upd   (upd),
    .vld   (arb_vld),
    .gnt   (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cur   <= 1'b0;
      busy  <= 1'b0;
      stb   <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      be    <= '0;
      ack   <= '0;
      err   <= '0;
      rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            cur   <= arb_gnt;
            we    <= arb_gnt ? bus.i_m1_we    : bus.i_m0_we;
            addr  <= arb_gnt ? bus.i_m1_addr  : bus.i_m0_addr;
            wdata <= arb_gnt ? bus.i_m1_wdata : bus.i_m0_wdata;
            be    <= arb_gnt ? bus.i_m1_be    : bus.i_m0_be;
            stb   <= 1'b1;
            busy  <= 1'b1;
            cnt   <= 8'(TIMEOUT);
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // ack has priority over expiry in the same cycle
          if (bus.i_rd_ack) begin
            stb        <= 1'b0;
            ack[cur]   <= 1'b1;
            rdata[cur] <= we ? 32'd0 : bus.i_read_data;
            state      <= ST_DONE;
          end else if (cnt == 8'd1) begin
            // last allowed strobe cycle just ended without ack
            stb      <= 1'b0;
            ack[cur] <= 1'b1;
            err[cur] <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_DONE: begin
          ack   <= '0;
          err   <= '0;
          rdata <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_stb      = stb;
  assign bus.o_MemSrc   = we;
  assign bus.o_addr     = addr;
  assign bus.o_wr_data  = wdata;
  assign bus.o_be       = be;
  assign bus.o_busy     = busy;
  assign bus.o_m0_ack   = ack[0];
  assign bus.o_m1_ack   = ack[1];
  assign bus.o_m0_err   = err[0];
  assign bus.o_m1_err   = err[1];
  assign bus.o_m0_rdata = rdata[0];
  assign bus.o_m1_rdata = rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus randomized transactions against a
// transaction-level model (request set + last winner -> grant; ack latency
// vs TIMEOUT -> strobe length, err and rdata).
module tb_dmem_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // model state
  bit          rq   [2];
  logic        we_q [2];
  logic [31:0] ad_q [2];
  logic [31:0] wd_q [2];
  logic [3:0]  be_q [2];
  int          last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    bus.i_m0_stb   = rq[0];   bus.i_m1_stb   = rq[1];
    bus.i_m0_we    = we_q[0]; bus.i_m1_we    = we_q[1];
    bus.i_m0_addr  = ad_q[0]; bus.i_m1_addr  = ad_q[1];
    bus.i_m0_wdata = wd_q[0]; bus.i_m1_wdata = wd_q[1];
    bus.i_m0_be    = be_q[0]; bus.i_m1_be    = be_q[1];
  endtask

  task automatic setreq(input int m, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    rq[m] = 1'b1; we_q[m] = w; ad_q[m] = a; wd_q[m] = d; be_q[m] = b;
  endtask

  task automatic newreq(input int m);
    setreq(m, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
  endtask

  // Starts at an IDLE-state negedge with rq[] set; ends at the next IDLE negedge.
  // lat: strobe cycle in which memory acks (lat > TO means never).
  task automatic txn(input int lat, input logic [31:0] rd, input bit keep, input bit drop);
    int win, n;
    logic [31:0] exp_rd;
    win = (rq[0] && rq[1]) ? (last == 1 ? 0 : 1) : (rq[0] ? 0 : 1);
    drive();
    @(negedge clk);
    chk("grant_stb",   bus.o_stb, 1);
    chk("grant_busy",  bus.o_busy, 1);
    chk("grant_addr",  bus.o_addr, ad_q[win]);
    chk("grant_we",    bus.o_MemSrc, we_q[win]);
    chk("grant_wdata", bus.o_wr_data, wd_q[win]);
    chk("grant_be",    bus.o_be, be_q[win]);
    n = 0;
    while (bus.o_stb === 1'b1 && n < TO + 4) begin
      n++;
      chk("hold_addr",  bus.o_addr, ad_q[win]);
      chk("hold_wdata", bus.o_wr_data, wd_q[win]);
      chk("early_ack",  bus.o_m0_ack | bus.o_m1_ack, 0);
      if (drop && n == 1) begin
        rq[win] = 1'b0;
        drive();
      end
      bus.i_rd_ack    = (n == lat);
      bus.i_read_data = (n == lat) ? rd : $urandom;
      @(negedge clk);
    end
    bus.i_rd_ack = 1'b0;
    exp_rd = (lat <= TO && !we_q[win]) ? rd : 32'd0;
    chk("stb_cycles", n, (lat <= TO) ? lat : TO);
    chk("done_busy",  bus.o_busy, 1);
    chk("ack_win",    win ? bus.o_m1_ack : bus.o_m0_ack, 1);
    chk("ack_other",  win ? bus.o_m0_ack : bus.o_m1_ack, 0);
    chk("err_win",    win ? bus.o_m1_err : bus.o_m0_err, (lat > TO) ? 1 : 0);
    chk("err_other",  win ? bus.o_m0_err : bus.o_m1_err, 0);
    chk("rdata_win",  win ? bus.o_m1_rdata : bus.o_m0_rdata, exp_rd);
    last = win;
    if (!keep) rq[win] = 1'b0;
    drive();
    @(negedge clk);
    chk("ack_clear", bus.o_m0_ack | bus.o_m1_ack, 0);
    chk("idle_busy", bus.o_busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int lat;
    bit kp, dr;
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      rq[m] = 1'b0; we_q[m] = 1'b0; ad_q[m] = '0; wd_q[m] = '0; be_q[m] = '0;
    end
    drive();
    bus.i_rd_ack = 1'b0;
    bus.i_read_data = '0;
    last = 1;
    repeat (2) @(negedge clk);
    chk("rst_stb",   bus.o_stb, 0);
    chk("rst_busy",  bus.o_busy, 0);
    chk("rst_ack",   {bus.o_m0_ack, bus.o_m1_ack, bus.o_m0_err, bus.o_m1_err}, 0);
    chk("rst_addr",  bus.o_addr, 0);
    chk("rst_we",    bus.o_MemSrc, 0);
    chk("rst_rdata", bus.o_m0_rdata | bus.o_m1_rdata, 0);
    rst_n = 1'b1;

    // contention from reset, both held high: 0,1,0,1
    setreq(0, 1'b0, 32'h0000_1000, 32'h0, 4'hf);
    setreq(1, 1'b0, 32'h0000_2000, 32'h0, 4'hf);
    for (int i = 0; i < 4; i++) txn(2, 32'hA000_0000 + i, 1'b1, 1'b0);
    rq[0] = 1'b0; rq[1] = 1'b0;
    drive();

    // single load, ack after 2 cycles
    setreq(0, 1'b0, 32'h100, 32'h0, 4'hf);
    txn(2, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // store from m1
    setreq(1, 1'b1, 32'h40, 32'h1234_5678, 4'b0011);
    txn(3, 32'h5555_AAAA, 1'b0, 1'b0);

    // timeout, then ack coinciding with expiry
    setreq(0, 1'b0, 32'h200, 32'h0, 4'hf);
    txn(TO + 1, 32'h0BAD_0BAD, 1'b0, 1'b0);
    setreq(0, 1'b0, 32'h204, 32'h0, 4'hf);
    txn(TO, 32'hCAFE_F00D, 1'b0, 1'b0);

    // stray ack in IDLE is ignored
    bus.i_rd_ack = 1'b1;
    bus.i_read_data = 32'h1111_2222;
    @(negedge clk);
    bus.i_rd_ack = 1'b0;
    chk("stray_busy", bus.o_busy, 0);
    chk("stray_stb",  bus.o_stb, 0);
    chk("stray_ack",  bus.o_m0_ack | bus.o_m1_ack, 0);
    @(negedge clk);
    chk("stray_ack2", bus.o_m0_ack | bus.o_m1_ack, 0);

    // randomized traffic
    for (int t = 0; t < 200; t++) begin
      for (int m = 0; m < 2; m++)
        if (!rq[m] && $urandom_range(0, 1) == 1) newreq(m);
      if (!rq[0] && !rq[1]) newreq(int'($urandom_range(0, 1)));
      lat = int'($urandom_range(1, TO + 1));
      kp  = ($urandom_range(0, 3) == 0);
      dr  = !kp && ($urandom_range(0, 3) == 0);
      txn(lat, $urandom, kp, dr);
    end
    rq[0] = 1'b0; rq[1] = 1'b0;
    drive();
    @(negedge clk);

    // reset while BUSY: outputs drop at once, m0 wins first after release
    setreq(0, 1'b0, 32'h300, 32'h0, 4'hf);
    setreq(1, 1'b0, 32'h400, 32'h0, 4'hf);
    drive();
    @(negedge clk);
    chk("pre_rst_stb", bus.o_stb, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_stb",  bus.o_stb, 0);
    chk("async_rst_busy", bus.o_busy, 0);
    @(negedge clk);
    chk("rst_no_ack", bus.o_m0_ack | bus.o_m1_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last = 1;
    txn(2, 32'h7777_0000, 1'b0, 1'b0);
    txn(1, 32'h7777_0001, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter and sequencer for the single data-memory port. Master 0 is the core's memory stage; master 1 is a secondary requester (DMA/debug loader). The block grants the port round-robin, drives the strobe/write/address/data lines toward data memory, and waits for the memory acknowledge. It returns a registered acknowledge, read data and error flag to the granted master, and aborts a transaction on timeout.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles to wait for `i_rd_ack` before abort; range 1..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assertion, active-low.
- `i_m0_stb`, `i_m1_stb`  in  1  request from master 0/1; held until that master's ack.
- `i_m0_we`, `i_m1_we`  in  1  1 = store, 0 = load.
- `i_m0_addr`, `i_m1_addr`  in  32  byte address.
- `i_m0_wdata`, `i_m1_wdata`  in  32  store data, already lane-aligned.
- `i_m0_be`, `i_m1_be`  in  4  byte enables.
- `o_m0_ack`, `o_m1_ack`  out  1  one-cycle completion pulse.
- `o_m0_rdata`, `o_m1_rdata`  out  32  load data; valid only in the ack cycle.
- `o_m0_err`, `o_m1_err`  out  1  timeout flag; pulses together with ack.
- `o_stb`  out  1  memory strobe.
- `o_MemSrc`  out  1  memory write enable.
- `o_addr`  out  32  memory address.
- `o_wr_data`  out  32  memory write data.
- `o_be`  out  4  memory byte enables.
- `i_rd_ack`  in  1  memory acknowledge, one cycle.
- `i_read_data`  in  32  memory read data; valid with `i_rd_ack`.
- `o_busy`  out  1  high while a transaction is outstanding.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY: transaction outstanding to memory.
  - DONE: one-cycle response state.
- IDLE behaviour:
  - Sample both strobes.
  - One request only: grant that master.
  - Both requesting: grant the master not recorded in `last_grant`.
  - On a grant: latch that master's we/addr/wdata/be into the output registers, set `o_stb`=1, load the timeout counter with `TIMEOUT`, go to BUSY, and update `last_grant`.
- BUSY behaviour:
  - Output registers hold constant.
  - Counter decrements by 1 each cycle.
  - `i_rd_ack`=1: latch `i_read_data` (forced to 0 for stores), clear `o_stb`, go to DONE with err=0.
  - Counter reaches 0 with no ack: clear `o_stb`, go to DONE with err=1 and rdata=0.
  - If ack and counter expiry occur in the same cycle, the ack wins (err=0).
- DONE behaviour:
  - Pulse the granted master's ack (and err if set) for exactly one cycle.
  - Return to IDLE.
  - The non-granted master's ack/err stay 0.
- Boundary rules:
  - `i_rd_ack` arriving in IDLE or DONE is ignored.
  - A master that drops its strobe during BUSY does not cancel the transaction; it completes and the ack is still pulsed.
  - A master still asserting its strobe in IDLE after its ack is treated as a new request.
  - Arbitration order is fixed by `last_grant`, so one master cannot starve the other: with both strobes permanently high, grants alternate 0,1,0,1.
- Reset behaviour:
  - `rst_n` low forces IDLE immediately, without waiting for a clock edge.
  - All outputs go to 0.
  - `last_grant` resets to 1, so master 0 wins the first contention.
  - A transaction in flight is dropped; no ack is issued for it.

## Timing
- Request sampled in IDLE at edge N: `o_stb`, `o_addr` and the other memory outputs are valid after edge N, i.e. in cycle N+1.
- Ack sampled at edge M: DONE in cycle M+1, with master ack/rdata/err valid for that one cycle.
- IDLE is re-entered in cycle M+2. The earliest next `o_stb` is cycle M+3, so minimum turnaround is 3 cycles plus memory latency.
- Timeout: with no ack, `o_stb` stays high for exactly `TIMEOUT` cycles, then err is pulsed in the following DONE cycle.
- `o_busy` = (state != IDLE); it is registered.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package/header (`parameters.vh`): FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the `DMEM_TIMEOUT_DEFAULT` constant.
- One natural sub-module, `rr_arb2`: a 2-input round-robin grant with a `last_grant` register and an update enable. The top level holds the FSM, the timeout counter and the datapath registers.

## Test plan
- Single load, m0 reads addr 0x100, memory acks after 2 cycles with 0xDEADBEEF -> `o_m0_ack` pulses 1 cycle, `o_m0_rdata`=0xDEADBEEF, `o_m0_err`=0, `o_m1_ack` stays 0.
- Contention from reset: both masters request at the same edge -> m0 is granted first (`o_addr`=m0 addr), then m1; with both held high, grants alternate 0,1,0,1 over 4 transactions.
- Store, m1 writes 0x12345678 to 0x40 with be=4'b0011 -> `o_MemSrc`=1, `o_be`=0011, `o_wr_data`=0x12345678 held stable until ack; `o_m1_rdata`=0 at ack.
- Timeout with `TIMEOUT`=4 and memory never acking -> `o_stb` high exactly 4 cycles, then `o_m0_ack`=`o_m0_err`=1 for 1 cycle, rdata=0.
- Late ack: `i_rd_ack` pulsed while in IDLE -> no master ack and no state change; ack in the same cycle as counter expiry -> err=0.
- Reset mid-BUSY: `rst_n` low between edges -> `o_stb`/`o_busy` go to 0 immediately; after release, m0's request is granted in the first IDLE cycle.
